mandelbrot_iter: RTL

MANDELBROT_ITER -- requirements
Module: mandelbrot_iter

---
 rtl/mandelbrot_iter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mandelbrot_iter.sv
// mandelbrot_iter
// ----------------------------------------------------------------------------
// Iterative Mandelbrot escape-time engine. The engine takes one point c and
// iterates z <- z^2 + c (starting at z = 0), one iteration per clock. It
// reports how many iterations ran before |z|^2 exceeded 4.0, or MAX_ITER if
// the point never escaped. Only one point is in flight at a time.
//
// Numbers are signed fixed point Q(WIDTH-FRAC).FRAC.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   in_valid      c_re/c_im carry a point
//   in_ready      engine is idle and will accept a point this cycle
//   c_re, c_im    point coordinates, legal range [-2.0, 2.0)
//   out_valid     escape_count holds a finished result
//   out_ready     downstream accepts the result
//   escape_count  iteration count at escape, or MAX_ITER
// ----------------------------------------------------------------------------
module mandelbrot_iter #(
  parameter int WIDTH    = 18,
  parameter int FRAC     = 14,
  parameter int MAX_ITER = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] c_re,
  input  logic signed [WIDTH-1:0] c_im,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [7:0]              escape_count
);

  // Products are formed at double width so nothing is lost before the
  // fractional shift; the magnitude only needs WIDTH+2 bits because the
  // escape test keeps |z| small enough that |z|^2 stays well under 64.
  localparam int PW = 2 * WIDTH;
  localparam int MW = WIDTH + 2;
  localparam logic [MW-1:0] FOUR = MW'(4) << FRAC;
  localparam logic [7:0]    ITER_CAP = 8'(MAX_ITER);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_reg;
  logic signed [WIDTH-1:0] c_re_reg;
  logic signed [WIDTH-1:0] c_im_reg;
  logic signed [WIDTH-1:0] z_re_reg;
  logic signed [WIDTH-1:0] z_im_reg;
  logic [7:0]              n_reg;
  logic [7:0]              count_reg;
  logic                    in_ready_reg;
  logic                    out_valid_reg;

  // --------------------------------------------------------------------------
  // Datapath: one full iteration step evaluated combinationally from z
  // --------------------------------------------------------------------------
  logic signed [PW-1:0] z_re_ext;
  logic signed [PW-1:0] z_im_ext;
  logic signed [PW-1:0] c_re_ext;
  logic signed [PW-1:0] c_im_ext;
  logic signed [PW-1:0] zr2;
  logic signed [PW-1:0] zi2;
  logic signed [PW-1:0] zri;
  logic [MW-1:0]        mag;
  logic                 escaped;
  logic                 at_cap;
  logic signed [WIDTH-1:0] z_re_next;
  logic signed [WIDTH-1:0] z_im_next;

  // Size casts of signed operands sign-extend.
  assign z_re_ext = PW'(z_re_reg);
  assign z_im_ext = PW'(z_im_reg);
  assign c_re_ext = PW'(c_re_reg);
  assign c_im_ext = PW'(c_im_reg);

  assign zr2 = (z_re_ext * z_re_ext) >>> FRAC;
  assign zi2 = (z_im_ext * z_im_ext) >>> FRAC;
  assign zri = (z_re_ext * z_im_ext) >>> FRAC;

  // Both squares are non-negative, so the sum is treated as unsigned.
  assign mag     = MW'(zr2 + zi2);
  assign escaped = (mag > FOUR);
  assign at_cap  = (n_reg == ITER_CAP);

  // The escape test precedes every update, so only |z| <= 2 reaches here and
  // the truncation to WIDTH never wraps for legal c.
  assign z_re_next = WIDTH'(zr2 - zi2 + c_re_ext);
  assign z_im_next = WIDTH'((zri <<< 1) + c_im_ext);

  // --------------------------------------------------------------------------
  // Control FSM with registered handshake outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      c_re_reg      <= '0;
      c_im_reg      <= '0;
      z_re_reg      <= '0;
      z_im_reg      <= '0;
      n_reg         <= '0;
      count_reg     <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            c_re_reg     <= c_re;
            c_im_reg     <= c_im;
            z_re_reg     <= '0;
            z_im_reg     <= '0;
            n_reg        <= '0;
            in_ready_reg <= 1'b0;
            state_reg    <= ITER;
          end
        end

        ITER: begin
          if (escaped) begin
            count_reg <= n_reg;
            state_reg <= DONE;
          end else if (at_cap) begin
            count_reg <= ITER_CAP;
            state_reg <= DONE;
          end else begin
            z_re_reg <= z_re_next;
            z_im_reg <= z_im_next;
            n_reg    <= n_reg + 8'd1;
          end
        end

        DONE: begin
          // The count is registered on DONE entry; out_valid follows one
          // cycle later so the color mapper always sees a settled count
          // straight from a flop. The handshake only completes once
          // out_valid is actually presented.
          if (!out_valid_reg) begin
            out_valid_reg <= 1'b1;
          end else if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end

        default: begin
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready     = in_ready_reg;
  assign out_valid    = out_valid_reg;
  assign escape_count = count_reg;

endmodule
